sprite_cmd_scheduler: RTL

SPRITE_CMD_SCHEDULER -- requirements
Module: sprite_cmd_scheduler

---
 rtl/sprite_pkg.sv | 40 ++++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/sprite_cmd_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite command scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sprite_pkg;

    // Command word field positions.
    localparam int COMP_MSB  = 31;
    localparam int COMP_LSB  = 26;
    localparam int CHILD_MSB = 25;
    localparam int CHILD_LSB = 21;
    localparam int ACT_MSB   = 20;
    localparam int ACT_LSB   = 17;
    localparam int TYPE_MSB  = 16;
    localparam int TYPE_LSB  = 14;
    localparam int BANK_BIT  = 13;
    localparam int DATA_MSB  = 12;
    localparam int DATA_LSB  = 0;

    localparam logic [5:0] COMMIT_ID  = 6'h3F;
    localparam logic [3:0] ACT_UPDATE = 4'h1;
    localparam logic [3:0] ACT_TOGGLE = 4'hF;
    localparam logic [9:0] VBL_LINE   = 10'd480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VBL,
        ST_FLIP
    } sched_state_t;

    // Bank-toggle command for one component; child, type and data stay zero.
    function automatic logic [31:0] toggle_cmd(input logic [5:0] comp, input logic bank);
        logic [31:0] w;
        w = '0;
        w[COMP_MSB:COMP_LSB] = comp;
        w[ACT_MSB:ACT_LSB]   = ACT_TOGGLE;
        w[BANK_BIT]          = bank;
        return w;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; head word is read straight from registered storage.
// Latency: a word pushed at edge N is visible on head_dat after edge N.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports: clk/reset (sync, active high), push/push_dat in, pop in,
//        head_dat/full/empty out. pop is ignored while empty.
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a word.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Queues host sprite commands and replays them to the display blocks, with vblank-synchronised bank flips.
// Latency: word accepted at edge N into an empty FIFO in IDLE is on cmd_out after edge N+1.
// Backpressure: none towards the host; writes into a full FIFO are dropped and flagged in sticky overflow.
// Ports: clk, reset (sync, active high); writedata/write/chipselect host write port;
//        hcount/vcount raster position; cmd_out broadcast command (0 when idle);
//        front_bank displayed bank; fifo_full; overflow.
module sprite_cmd_scheduler
    import sprite_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_COMP   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        front_bank,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int IDX_W = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

    sched_state_t       state;
    sched_state_t       state_nxt;
    logic [NUM_COMP-1:0] flip_mask;
    logic [NUM_COMP-1:0] mask_nxt;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic               bank_nxt;
    logic [31:0]        cmd_nxt;

    logic               host_wr;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [31:0]        fifo_head;
    logic [5:0]         head_comp;

    logic               vbl_now;
    logic               vbl_q;
    logic               vbl_rise;

    assign host_wr   = write && chipselect;
    assign head_comp = fifo_head[COMP_MSB:COMP_LSB];

    // Only the first cycle of line VBL_LINE / column 0 starts the flip, so a
    // raster position that lingers there cannot retrigger it.
    assign vbl_now  = (vcount == VBL_LINE) && (hcount == 10'd0);
    assign vbl_rise = vbl_now && !vbl_q;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (host_wr),
        .push_dat (writedata),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        cmd_nxt   = '0;
        fifo_pop  = 1'b0;
        mask_nxt  = flip_mask;
        idx_nxt   = scan_idx;
        bank_nxt  = front_bank;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_comp == COMMIT_ID) begin
                        mask_nxt  = fifo_head[DATA_LSB +: NUM_COMP];
                        state_nxt = ST_WAIT_VBL;
                    end else if (head_comp != 6'd0) begin
                        // Component 0 would look like a null command downstream; such words are consumed silently.
                        cmd_nxt           = fifo_head;
                        cmd_nxt[BANK_BIT] = ~front_bank;
                    end
                end
            end
            ST_WAIT_VBL: begin
                if (vbl_rise) begin
                    state_nxt = ST_FLIP;
                    idx_nxt   = '0;
                end
            end
            ST_FLIP: begin
                if (flip_mask[scan_idx]) begin
                    cmd_nxt = toggle_cmd(6'(scan_idx) + 6'd1, ~front_bank);
                end
                if (scan_idx == IDX_W'(NUM_COMP - 1)) begin
                    idx_nxt   = '0;
                    bank_nxt  = ~front_bank;
                    state_nxt = ST_IDLE;
                end else begin
                    idx_nxt = scan_idx + IDX_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_out    <= '0;
            front_bank <= 1'b0;
            flip_mask  <= '0;
            scan_idx   <= '0;
            vbl_q      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd_out    <= cmd_nxt;
            front_bank <= bank_nxt;
            flip_mask  <= mask_nxt;
            scan_idx   <= idx_nxt;
            vbl_q      <= vbl_now;
            if (host_wr && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
